rr_arbiter8: RTL



---
 rtl/rr_arbiter8.sv | 110 +++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index,
// owner hold until done/request drop, and a forced release after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_d;
  logic [2:0] idx_d;
  logic       valid_d;
  logic       timeout_d;
  logic [2:0] winner;
  logic       rel_normal;
  logic       rel_limit;

  // First set request found scanning upward from the rotate pointer, wrapping at 7.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] dbl;
    logic [2:0]  off;
    dbl = {r, r} >> p;
    off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (dbl[k]) off = 3'(k);
    end
    return p + off;
  endfunction

  assign winner     = rr_pick(req, ptr_q);
  assign rel_normal = done | ~req[own_q];
  assign rel_limit  = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d   = 8'd0;
        idx_d   = 3'd0;
        valid_d = 1'b0;
        if (req != 8'd0) begin
          state_d = GRANT;
          own_d   = winner;
          gnt_d   = 8'd1 << winner;
          idx_d   = winner;
          valid_d = 1'b1;
          ptr_d   = winner + 3'd1;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (rel_normal || rel_limit) begin
          state_d   = IDLE;
          gnt_d     = 8'd0;
          idx_d     = 3'd0;
          valid_d   = 1'b0;
          // A voluntary release in the same cycle as the limit is not a timeout.
          timeout_d = rel_limit & ~rel_normal;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      own_q     <= 3'd0;
      cnt_q     <= 8'd0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
